// File: rtl/instr_encoder.sv
// instr_encoder: packs raw RV32 instruction fields into a 32-bit word and
// presents it, with its instruction-memory byte address, on a
// valid/ready output register stage.
//
// Build option: define INSTR_ENC_RANGE_CHECK_EN to reject immediates that
// do not fit their format (and reserved fmt 6/7). A rejected input is
// consumed, flagged on enc_err for one cycle and never reaches the output.
// Without the macro every input is encoded by silent truncation, fmt 6/7
// become a NOP, and enc_err is constant 0.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic [31:0] out_addr,
  output logic        enc_err
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        out_valid_q;
  logic [31:0] instr_q;
  logic [31:0] out_addr_q;
  logic        enc_err_q;

  logic [31:0] instr_d;
  logic        bad_d;
  logic        accept;
  logic        out_fire;

  // Single register stage: a new word may enter when the slot is empty or
  // is being emptied in this same cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // Pack the fields of the presented input according to its format.
  always_comb begin
    // NOTE: instr_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    instr_d = NOP;
    case (fmt)
      FMT_R: instr_d = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: instr_d = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: instr_d = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: instr_d = {imm[12], imm[10:5], rs2, rs1, funct3,
                        imm[4:1], imm[11], opcode};
      FMT_U: instr_d = {imm[31:12], rd, opcode};
      FMT_J: instr_d = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: instr_d = NOP;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  // Flag immediates that would lose information when packed, and reserved formats.
  always_comb begin
    bad_d = 1'b0;
    case (fmt)
      FMT_R:        bad_d = 1'b0;
      FMT_I, FMT_S: bad_d = (imm[31:11] != {21{imm[11]}});
      FMT_B:        bad_d = (imm[31:12] != {20{imm[12]}}) || imm[0];
      FMT_U:        bad_d = (imm[11:0] != 12'd0);
      FMT_J:        bad_d = (imm[31:20] != {12{imm[20]}}) || imm[0];
      default:      bad_d = 1'b1;
    endcase
  end
`else
  assign bad_d = 1'b0;
`endif

  // Output register stage, address counter and error pulse.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      out_valid_q <= 1'b0;
      instr_q     <= 32'd0;
      out_addr_q  <= BASE_ADDR;
      enc_err_q   <= 1'b0;
    end else begin
      enc_err_q <= accept && bad_d;
      if (out_fire) begin
        out_addr_q <= out_addr_q + 32'd4;
      end
      if (accept && !bad_d) begin
        out_valid_q <= 1'b1;
        instr_q     <= instr_d;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign instr     = instr_q;
  assign out_addr  = out_addr_q;
  assign enc_err   = enc_err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios followed by a
// randomized run, all scored against a queue-based reference model.
module tb_instr_encoder;

  // Base close to the top of the address space so the counter wraps.
  localparam logic [31:0] BASE = 32'hFFFF_FFF8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [31:0] out_addr;
  logic        enc_err;

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .out_addr  (out_addr),
    .enc_err   (enc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: words accepted but not yet delivered, the address the
  // next delivered word must carry, and whether an error pulse is due.
  logic [31:0] sb_q[$];
  logic [31:0] exp_addr;
  logic        err_pending;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // RV32 bit placement built from shifted field slices.
  function automatic logic [31:0] ref_encode(input logic [2:0] f, input logic [6:0] op,
                                             input logic [4:0] r_d, input logic [4:0] r_s1,
                                             input logic [4:0] r_s2, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [31:0] im);
    logic [31:0] base;
    base = 32'(op);
    case (f)
      3'd0: return base | (32'(f7) << 25) | (32'(r_s2) << 20) | (32'(r_s1) << 15)
                        | (32'(f3) << 12) | (32'(r_d) << 7);
      3'd1: return base | (fld(im, 11, 0) << 20) | (32'(r_s1) << 15)
                        | (32'(f3) << 12) | (32'(r_d) << 7);
      3'd2: return base | (fld(im, 11, 5) << 25) | (32'(r_s2) << 20) | (32'(r_s1) << 15)
                        | (32'(f3) << 12) | (fld(im, 4, 0) << 7);
      3'd3: return base | (fld(im, 12, 12) << 31) | (fld(im, 10, 5) << 25)
                        | (32'(r_s2) << 20) | (32'(r_s1) << 15) | (32'(f3) << 12)
                        | (fld(im, 4, 1) << 8) | (fld(im, 11, 11) << 7);
      3'd4: return (im & 32'hFFFF_F000) | (32'(r_d) << 7) | base;
      3'd5: return base | (fld(im, 20, 20) << 31) | (fld(im, 10, 1) << 21)
                        | (fld(im, 11, 11) << 20) | (fld(im, 19, 12) << 12)
                        | (32'(r_d) << 7);
      default: return 32'h0000_0013;
    endcase
  endfunction

  // Whether the input may be encoded, expressed as numeric ranges.
  function automatic logic ref_ok(input logic [2:0] f, input logic [31:0] im);
`ifdef INSTR_ENC_RANGE_CHECK_EN
    int s;
    s = signed'(im);
    case (f)
      3'd0:       return 1'b1;
      3'd1, 3'd2: return (s >= -2048) && (s <= 2047);
      3'd3:       return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
      3'd4:       return (im % 4096) == 0;
      3'd5:       return (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
      default:    return 1'b0;
    endcase
`else
    return (f == f) || (im == im);
`endif
  endfunction

  // Drive one cycle of inputs, score the visible outputs, advance the model.
  task automatic step(input logic iv, input logic [2:0] f, input logic [6:0] op,
                      input logic [4:0] r_d, input logic [4:0] r_s1, input logic [4:0] r_s2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im,
                      input logic ordy);
    logic        ev;
    logic        acc;
    logic [31:0] w;
    in_valid = iv; fmt = f; opcode = op; rd = r_d; rs1 = r_s1; rs2 = r_s2;
    funct3 = f3; funct7 = f7; imm = im; out_ready = ordy;
    #1;
    ev = (sb_q.size() != 0);
    check("out_valid", 32'(out_valid), 32'(ev));
    check("in_ready", 32'(in_ready), 32'(!ev || ordy));
    check("enc_err", 32'(enc_err), 32'(err_pending));
    check("out_addr", out_addr, exp_addr);
    if (ev) check("instr", instr, sb_q[0]);
    acc = iv && (!ev || ordy);
    if (ev && ordy) begin
      w = sb_q.pop_front();
      exp_addr = exp_addr + 32'd4;
    end
    err_pending = 1'b0;
    if (acc) begin
      if (ref_ok(f, im)) sb_q.push_back(ref_encode(f, op, r_d, r_s1, r_s2, f3, f7, im));
      else err_pending = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, ordy);
  endtask

  // One reset edge, possibly colliding with a handshake, then check reset state.
  task automatic apply_reset(input logic iv, input logic ordy);
    rst = 1'b1; in_valid = iv; out_ready = ordy;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sb_q.delete();
    exp_addr = BASE;
    err_pending = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_enc_err", 32'(enc_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] edges [10] = '{32'd2047, 32'd2048, -32'd2048, -32'd2049, 32'd4095,
                                32'd4096, -32'd4096, 32'd1048575, 32'd1048576, -32'd1048576};
    case ($urandom_range(0, 4))
      0: return 32'($urandom_range(0, 64)) - 32'd32;
      1: return edges[$urandom_range(0, 9)];
      2: return $urandom() & 32'hFFFF_F000;
      3: return $urandom() & 32'hFFFF_FFFE;
      default: return $urandom();
    endcase
  endfunction

  logic [31:0] w_top;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; fmt = 3'd0; opcode = 7'd0;
    rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;
    sb_q.delete(); exp_addr = BASE; err_pending = 1'b0;

    apply_reset(1'b0, 1'b0);

    // addi x1, x0, 5: word visible one cycle after acceptance at BASE.
    step(1'b1, 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    check("i_type_valid", 32'(out_valid), 32'd1);
    check("i_type_instr", instr, 32'h0050_0093);
    check("i_type_addr", out_addr, BASE);

    // beq x1, x2, +8 accepted while the previous word drains.
    step(1'b1, 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b1);
    check("b_type_instr", instr, 32'h0020_8463);
    check("b_type_addr", out_addr, BASE + 32'd4);

    // jal x1, -4.
    step(1'b1, 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'd4, 1'b1);
    check("j_type_instr", instr, 32'hFFDF_F0EF);
    check("j_type_addr", out_addr, BASE + 32'd8);

    // lui x5, 0x12345; address has wrapped past zero by now.
    step(1'b1, 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1);
    check("u_type_instr", instr, 32'h1234_52B7);
    check("u_type_addr", out_addr, 32'h0000_0004);

    // Backpressure: sub x3, x4, x5 waits three cycles behind the held word.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd0, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0, 1'b0);
      check("stall_instr", instr, 32'h1234_52B7);
      check("stall_addr", out_addr, 32'h0000_0004);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    step(1'b1, 3'd0, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0, 1'b1);
    check("r_type_instr", instr, 32'h4052_01B3);
    check("r_type_addr", out_addr, 32'h0000_0008);
    idle(1'b1);
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_addr", out_addr, 32'h0000_000C);

    // I-type immediate one past the 12-bit signed range.
    step(1'b1, 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1);
`ifdef INSTR_ENC_RANGE_CHECK_EN
    check("range_err", 32'(enc_err), 32'd1);
    check("range_valid", 32'(out_valid), 32'd0);
    check("range_addr", out_addr, 32'h0000_000C);
    idle(1'b1);
    check("range_err_pulse", 32'(enc_err), 32'd0);
`else
    w_top = instr;
    check("trunc_imm", 32'(w_top[31:20]), 32'h800);
    check("trunc_err", 32'(enc_err), 32'd0);
    idle(1'b1);
`endif

    // Reset while a word is held under backpressure, with a handshake pending.
    step(1'b1, 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    idle(1'b0);
    check("held_valid", 32'(out_valid), 32'd1);
    apply_reset(1'b1, 1'b1);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        apply_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        step(1'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), 7'($urandom()),
             5'($urandom()), 5'($urandom()), 5'($urandom()), 3'($urandom()),
             7'($urandom()), rand_imm(), 1'($urandom_range(0, 3) != 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
